// File: rtl/uart_rx_cfg.sv
// Configurable oversampling UART receiver: 5-9 data bits, none/odd/even parity, 1-2 stop bits.
// Optional break detection is compiled in with `define UART_RX_BREAK_DETECT_EN.
module uart_rx_cfg #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD_RATE  = 19200,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_rx_serial,
    output logic [DATA_BITS-1:0] o_rx_data,
    output logic                 o_rx_valid,
    input  logic                 i_rx_ready,
    output logic                 o_parity_err,
    output logic                 o_frame_err,
    output logic                 o_overrun,
`ifdef UART_RX_BREAK_DETECT_EN
    output logic                 o_break,
`endif
    output logic                 o_busy
);

    localparam int DIV   = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int OS_W  = $clog2(OVERSAMPLE);
    localparam int MID   = OVERSAMPLE / 2;

    generate
        if (DIV < 1) begin : g_div_check
            $error("uart_rx_cfg: CLK_FREQ too low for BAUD_RATE * OVERSAMPLE");
        end
        if (OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0) begin : g_os_check
            $error("uart_rx_cfg: OVERSAMPLE must be even and >= 8");
        end
        if (DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
            STOP_BITS < 1 || STOP_BITS > 2) begin : g_fmt_check
            $error("uart_rx_cfg: unsupported frame format");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
`ifdef UART_RX_BREAK_DETECT_EN
        , S_BREAK
`endif
    } state_t;

    state_t               state_q, state_d;
    logic                 rx_meta_q, rx_meta_d;
    logic                 rx_s_q, rx_s_d;
    logic                 armed_q, armed_d;
    logic [DIV_W-1:0]     div_cnt_q, div_cnt_d;
    logic [OS_W-1:0]      tick_cnt_q, tick_cnt_d;
    logic [3:0]           bit_cnt_q, bit_cnt_d;
    logic [1:0]           vote_q, vote_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic                 done_q, done_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 perr_out_q, perr_out_d;
    logic                 ferr_out_q, ferr_out_d;
    logic                 overrun_q, overrun_d;
`ifdef UART_RX_BREAK_DETECT_EN
    logic                 zero_q, zero_d;
    logic                 brk_done_q, brk_done_d;
    logic                 break_q, break_d;
`endif

    logic       tick;
    logic       sample_win;
    logic       decide;
    logic       bit_end;
    logic [1:0] votes_total;
    logic       bit_val;
    logic       exp_par;
    logic       xfer;

    assign tick        = (div_cnt_q == DIV_W'(DIV - 1));
    assign sample_win  = tick && (tick_cnt_q >= OS_W'(MID - 1)) && (tick_cnt_q <= OS_W'(MID + 1));
    assign decide      = tick && (tick_cnt_q == OS_W'(MID + 1));
    assign bit_end     = tick && (tick_cnt_q == OS_W'(OVERSAMPLE - 1));
    assign votes_total = vote_q + {1'b0, rx_s_q};
    // 2-of-3: at least two ones among the three window samples
    assign bit_val     = votes_total[1];
    assign exp_par     = (^shift_q) ^ (PARITY == 1);
    assign xfer        = rx_valid_q && i_rx_ready;

    // Receive FSM, tick generator and frame datapath
    always_comb begin
        state_d    = state_q;
        rx_meta_d  = i_rx_serial;
        rx_s_d     = rx_meta_q;
        armed_d    = armed_q;
        div_cnt_d  = tick ? '0 : div_cnt_q + DIV_W'(1);
        tick_cnt_d = tick_cnt_q;
        vote_d     = vote_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        done_d     = 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
        zero_d     = zero_q;
        brk_done_d = 1'b0;
`endif

        if (tick) begin
            tick_cnt_d = bit_end ? '0 : tick_cnt_q + OS_W'(1);
        end
        if (decide) begin
            vote_d = '0;
        end else if (sample_win) begin
            vote_d = votes_total;
        end

        case (state_q)
            S_IDLE: begin
                armed_d = armed_q | rx_s_q;
                if (armed_q && !rx_s_q) begin
                    state_d    = S_START;
                    armed_d    = 1'b0;
                    div_cnt_d  = '0;
                    tick_cnt_d = '0;
                    vote_d     = '0;
                    bit_cnt_d  = '0;
                    perr_d     = 1'b0;
                    ferr_d     = 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
                    zero_d     = 1'b1;
`endif
                end
            end
            S_START: begin
                if (decide && bit_val) begin
                    state_d = S_IDLE;
                end else if (bit_end) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (decide) begin
                    shift_d = {bit_val, shift_q[DATA_BITS-1:1]};
`ifdef UART_RX_BREAK_DETECT_EN
                    zero_d  = zero_q & ~bit_val;
`endif
                end
                if (bit_end) begin
                    if (bit_cnt_q == 4'(DATA_BITS - 1)) begin
                        bit_cnt_d = '0;
                        state_d   = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end
            S_PARITY: begin
                if (decide) begin
                    if (bit_val != exp_par) begin
                        perr_d = 1'b1;
                    end
`ifdef UART_RX_BREAK_DETECT_EN
                    zero_d = zero_q & ~bit_val;
`endif
                end
                if (bit_end) begin
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (decide) begin
                    ferr_d = ferr_q | ~bit_val;
`ifdef UART_RX_BREAK_DETECT_EN
                    zero_d = zero_q & ~bit_val;
`endif
                    // Leave at mid-bit so a start edge right after the stop bit is not missed
                    if (bit_cnt_q == 4'(STOP_BITS - 1)) begin
                        bit_cnt_d = '0;
                        state_d   = S_IDLE;
                        done_d    = 1'b1;
`ifdef UART_RX_BREAK_DETECT_EN
                        if (zero_q && !bit_val) begin
                            state_d    = S_BREAK;
                            done_d     = 1'b0;
                            brk_done_d = 1'b1;
                        end
`endif
                    end
                end else if (bit_end) begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                end
            end
`ifdef UART_RX_BREAK_DETECT_EN
            S_BREAK: begin
                if (rx_s_q) begin
                    state_d = S_IDLE;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // Host-side word register with handshake and overrun tracking
    always_comb begin
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
        perr_out_d = perr_out_q;
        ferr_out_d = ferr_out_q;
        overrun_d  = overrun_q;
        if (xfer) begin
            rx_valid_d = 1'b0;
            perr_out_d = 1'b0;
            ferr_out_d = 1'b0;
            overrun_d  = 1'b0;
        end
        if (done_q) begin
            if (!rx_valid_q || xfer) begin
                rx_data_d  = shift_q;
                perr_out_d = perr_q;
                ferr_out_d = ferr_q;
                rx_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
`ifdef UART_RX_BREAK_DETECT_EN
        break_d = brk_done_q;
`endif
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= S_IDLE;
            rx_meta_q  <= 1'b1;
            rx_s_q     <= 1'b1;
            armed_q    <= 1'b0;
            div_cnt_q  <= '0;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            vote_q     <= '0;
            shift_q    <= '0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            done_q     <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            perr_out_q <= 1'b0;
            ferr_out_q <= 1'b0;
            overrun_q  <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
            zero_q     <= 1'b0;
            brk_done_q <= 1'b0;
            break_q    <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            rx_meta_q  <= rx_meta_d;
            rx_s_q     <= rx_s_d;
            armed_q    <= armed_d;
            div_cnt_q  <= div_cnt_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            vote_q     <= vote_d;
            shift_q    <= shift_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            done_q     <= done_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            perr_out_q <= perr_out_d;
            ferr_out_q <= ferr_out_d;
            overrun_q  <= overrun_d;
`ifdef UART_RX_BREAK_DETECT_EN
            zero_q     <= zero_d;
            brk_done_q <= brk_done_d;
            break_q    <= break_d;
`endif
        end
    end

    assign o_rx_data    = rx_data_q;
    assign o_rx_valid   = rx_valid_q;
    assign o_parity_err = perr_out_q;
    assign o_frame_err  = ferr_out_q;
    assign o_overrun    = overrun_q;
    assign o_busy       = state_q inside {S_START, S_DATA, S_PARITY, S_STOP};
`ifdef UART_RX_BREAK_DETECT_EN
    assign o_break      = break_q;
`endif

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: three formats (8N1, 8E1, 5N2) side by side, scoreboard on the handshake.
// Break handling is exercised in both `UART_RX_BREAK_DETECT_EN builds.
module tb_uart_rx_cfg;

    localparam int CF  = 1_600_000;
    localparam int BR  = 100_000;
    localparam int OS  = 16;
    localparam int BIT = 16;

    typedef struct {
        int         inst;
        logic [8:0] data;
        logic       par_bit;
        logic       stop_val;
        logic [8:0] e_data;
        logic       e_pe;
        logic       e_fe;
    } vec_t;

    logic       clk;
    logic       rst;
    logic [2:0] line;
    logic [2:0] rdy;
    logic [7:0] d0, d1;
    logic [4:0] d2;
    logic [2:0] vld, perr, ferr, ovr, busy;
    logic [8:0] dat [3];
`ifdef UART_RX_BREAK_DETECT_EN
    logic [2:0] brk;
`endif

    logic [12:0] exp_q[$];
    int          n_cmp, n_err;
    int          cyc, fall_cyc, busy_cnt, brk_cnt;
    int          rise_cyc [3];
    logic [2:0]  vld_prev;
    vec_t        vq[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign dat[0] = {1'b0, d0};
    assign dat[1] = {1'b0, d1};
    assign dat[2] = {4'b0, d2};

    uart_rx_cfg #(.CLK_FREQ(CF), .BAUD_RATE(BR), .OVERSAMPLE(OS), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
        .i_clk(clk), .i_rst(rst), .i_rx_serial(line[0]), .o_rx_data(d0), .o_rx_valid(vld[0]),
        .i_rx_ready(rdy[0]), .o_parity_err(perr[0]), .o_frame_err(ferr[0]), .o_overrun(ovr[0]),
`ifdef UART_RX_BREAK_DETECT_EN
        .o_break(brk[0]),
`endif
        .o_busy(busy[0]));

    uart_rx_cfg #(.CLK_FREQ(CF), .BAUD_RATE(BR), .OVERSAMPLE(OS), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_8e1 (
        .i_clk(clk), .i_rst(rst), .i_rx_serial(line[1]), .o_rx_data(d1), .o_rx_valid(vld[1]),
        .i_rx_ready(rdy[1]), .o_parity_err(perr[1]), .o_frame_err(ferr[1]), .o_overrun(ovr[1]),
`ifdef UART_RX_BREAK_DETECT_EN
        .o_break(brk[1]),
`endif
        .o_busy(busy[1]));

    uart_rx_cfg #(.CLK_FREQ(CF), .BAUD_RATE(BR), .OVERSAMPLE(OS), .DATA_BITS(5), .PARITY(0), .STOP_BITS(2)) u_5n2 (
        .i_clk(clk), .i_rst(rst), .i_rx_serial(line[2]), .o_rx_data(d2), .o_rx_valid(vld[2]),
        .i_rx_ready(rdy[2]), .o_parity_err(perr[2]), .o_frame_err(ferr[2]), .o_overrun(ovr[2]),
`ifdef UART_RX_BREAK_DETECT_EN
        .o_break(brk[2]),
`endif
        .o_busy(busy[2]));

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, got, want);
        end
    endtask

    // Runs once per clock at the falling edge: pops and compares delivered words
    task automatic monitor_cycle();
        logic [12:0] got, want;
        if (!rst) begin
            if (busy[0]) busy_cnt++;
`ifdef UART_RX_BREAK_DETECT_EN
            if (brk[0]) brk_cnt++;
`endif
            for (int i = 0; i < 3; i++) begin
                if (vld[i] && !vld_prev[i]) rise_cyc[i] = cyc;
                if (vld[i] && rdy[i]) begin
                    got = {2'(i), perr[i], ferr[i], dat[i]};
                    n_cmp++;
                    if (exp_q.size() == 0) begin
                        n_err++;
                        $display("FAIL word_unexpected: inst %0d data %h pe %b fe %b, expected no word",
                                 i, dat[i], perr[i], ferr[i]);
                    end else begin
                        want = exp_q.pop_front();
                        if (got !== want) begin
                            n_err++;
                            $display("FAIL word: got inst %0d data %h pe %b fe %b, expected inst %0d data %h pe %b fe %b",
                                     got[12:11], got[8:0], got[10], got[9], want[12:11], want[8:0], want[10], want[9]);
                        end
                    end
                end
            end
        end
        vld_prev = vld;
    endtask

    task automatic step();
        @(negedge clk);
        monitor_cycle();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic send_bit(input int inst, input logic b);
        line[inst] = b;
        idle(BIT);
    endtask

    task automatic send_frame(input int inst, input logic [8:0] data, input logic par_bit, input logic stop_val);
        int nbits, nstop;
        nbits = (inst == 2) ? 5 : 8;
        nstop = (inst == 2) ? 2 : 1;
        fall_cyc = cyc;
        send_bit(inst, 1'b0);
        for (int i = 0; i < nbits; i++) send_bit(inst, data[i]);
        if (inst == 1) send_bit(inst, par_bit);
        for (int i = 0; i < nstop; i++) send_bit(inst, stop_val);
        line[inst] = 1'b1;
    endtask

    task automatic push_exp(input int inst, input logic [8:0] data, input logic pe, input logic fe);
        exp_q.push_back({2'(inst), pe, fe, data});
    endtask

    task automatic wait_drain(input int max_cycles);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < max_cycles) begin
            step();
            n++;
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain_timeout: %0d words still pending, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    function automatic vec_t mk(input int inst, input logic [8:0] data, input logic par_bit,
                                input logic stop_val, input logic [8:0] e_data, input logic e_pe, input logic e_fe);
        vec_t v;
        v.inst = inst; v.data = data; v.par_bit = par_bit; v.stop_val = stop_val;
        v.e_data = e_data; v.e_pe = e_pe; v.e_fe = e_fe;
        return v;
    endfunction

    initial begin
        logic [7:0] r;
        logic       pb;
        int         bc0, bk0;
        n_cmp = 0; n_err = 0; cyc = 0; fall_cyc = 0; busy_cnt = 0; brk_cnt = 0;
        rise_cyc = '{0, 0, 0};
        vld_prev = '0;
        line = '1;
        rdy  = '1;
        rst  = 1'b1;

        // Reset state
        idle(4);
        check("rst_data", 32'(d0), 32'h0);
        check("rst_valid", 32'(vld[0]), 32'h0);
        check("rst_perr", 32'(perr[0]), 32'h0);
        check("rst_ferr", 32'(ferr[0]), 32'h0);
        check("rst_overrun", 32'(ovr[0]), 32'h0);
        check("rst_busy", 32'(busy[0]), 32'h0);
        rst = 1'b0;
        idle(4);

        // 8N1 0xAA: word latency from line fall is 2 sync + 1 detect + 155 frame clocks
        push_exp(0, 9'h0AA, 1'b0, 1'b0);
        send_frame(0, 9'h0AA, 1'b0, 1'b1);
        idle(2 * BIT);
        wait_drain(200);
        check("latency_aa", 32'(rise_cyc[0] - fall_cyc), 32'd158);
        check("busy_after_aa", 32'(busy[0]), 32'h0);
        check("overrun_after_aa", 32'(ovr[0]), 32'h0);

        // Vector table: {inst, data, parity bit, stop value, expected data/pe/fe}
        vq.push_back(mk(1, 9'h05A, 1'b1, 1'b1, 9'h05A, 1'b1, 1'b0));
        vq.push_back(mk(1, 9'h05B, 1'b1, 1'b1, 9'h05B, 1'b0, 1'b0));
        vq.push_back(mk(0, 9'h03C, 1'b0, 1'b0, 9'h03C, 1'b0, 1'b1));
        vq.push_back(mk(0, 9'h03C, 1'b0, 1'b1, 9'h03C, 1'b0, 1'b0));
        vq.push_back(mk(2, 9'h015, 1'b0, 1'b1, 9'h015, 1'b0, 1'b0));
        vq.push_back(mk(2, 9'h00A, 1'b0, 1'b0, 9'h00A, 1'b0, 1'b1));
        vq.push_back(mk(0, 9'h0FF, 1'b0, 1'b1, 9'h0FF, 1'b0, 1'b0));
        vq.push_back(mk(0, 9'h001, 1'b0, 1'b1, 9'h001, 1'b0, 1'b0));
        vq.push_back(mk(1, 9'h000, 1'b0, 1'b1, 9'h000, 1'b0, 1'b0));
        vq.push_back(mk(1, 9'h0FF, 1'b1, 1'b1, 9'h0FF, 1'b1, 1'b0));
        vq.push_back(mk(1, 9'h080, 1'b1, 1'b0, 9'h080, 1'b0, 1'b1));
        for (int i = 0; i < 6; i++) begin
            r  = 8'($urandom_range(0, 255));
            pb = 1'($urandom_range(0, 1));
            // Even parity: the line bit should equal the XOR of the data bits
            vq.push_back(mk(1, {1'b0, r}, pb, 1'b1, {1'b0, r}, pb ^ (^r), 1'b0));
        end
        foreach (vq[k]) begin
            push_exp(vq[k].inst, vq[k].e_data, vq[k].e_pe, vq[k].e_fe);
            send_frame(vq[k].inst, vq[k].data, vq[k].par_bit, vq[k].stop_val);
            idle(2 * BIT);
            wait_drain(200);
        end

        // Overrun: two back-to-back words with the consumer stalled
        rdy[0] = 1'b0;
        push_exp(0, 9'h011, 1'b0, 1'b0);
        send_frame(0, 9'h011, 1'b0, 1'b1);
        send_frame(0, 9'h022, 1'b0, 1'b1);
        idle(3 * BIT);
        check("ovr_held_data", 32'(d0), 32'h11);
        check("ovr_valid", 32'(vld[0]), 32'h1);
        check("ovr_flag", 32'(ovr[0]), 32'h1);
        rdy[0] = 1'b1;
        step();
        rdy[0] = 1'b0;
        step();
        check("ovr_valid_cleared", 32'(vld[0]), 32'h0);
        check("ovr_flag_cleared", 32'(ovr[0]), 32'h0);
        check("ovr_queue_empty", 32'(exp_q.size()), 32'h0);
        rdy[0] = 1'b1;

        // False start: a 4-clock low glitch
        bc0 = busy_cnt;
        line[0] = 1'b0;
        idle(4);
        line[0] = 1'b1;
        idle(3 * BIT);
        check("glitch_busy_pulsed", 32'(busy_cnt > bc0), 32'h1);
        check("glitch_no_valid", 32'(vld[0]), 32'h0);
        check("glitch_busy_low", 32'(busy[0]), 32'h0);

        // Reset during data bit 3 of 0xFF
        send_bit(0, 1'b0);
        line[0] = 1'b1;
        idle(3 * BIT + BIT / 2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_data", 32'(d0), 32'h0);
        check("midrst_valid", 32'(vld[0]), 32'h0);
        check("midrst_perr", 32'(perr[0]), 32'h0);
        check("midrst_ferr", 32'(ferr[0]), 32'h0);
        check("midrst_overrun", 32'(ovr[0]), 32'h0);
        check("midrst_busy", 32'(busy[0]), 32'h0);
        idle(10 * BIT);
        check("midrst_no_word", 32'(vld[0]), 32'h0);
        push_exp(0, 9'h081, 1'b0, 1'b0);
        send_frame(0, 9'h081, 1'b0, 1'b1);
        idle(2 * BIT);
        wait_drain(200);

        // Line held low for 20 bit times
`ifdef UART_RX_BREAK_DETECT_EN
        bk0 = brk_cnt;
        line[0] = 1'b0;
        idle(20 * BIT);
        line[0] = 1'b1;
        idle(3 * BIT);
        check("break_pulses", 32'(brk_cnt - bk0), 32'd1);
        check("break_no_valid", 32'(vld[0]), 32'h0);
`else
        bk0 = 0;
        push_exp(0, 9'h000, 1'b0, 1'b1);
        line[0] = 1'b0;
        idle(20 * BIT);
        line[0] = 1'b1;
        idle(3 * BIT);
        wait_drain(200);
        check("break_extra_cnt", 32'(bk0 + brk_cnt), 32'd0);
`endif
        check("break_busy_low", 32'(busy[0]), 32'h0);

        // Clean frame after the break
        push_exp(0, 9'h0C3, 1'b0, 1'b0);
        send_frame(0, 9'h0C3, 1'b0, 1'b1);
        idle(2 * BIT);
        wait_drain(200);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_rx_cfg.md
Name: uart_rx_cfg

Overview:
Parametrised UART receiver that replaces the fixed 8N1 receive path inside uart_top.
- Oversamples the serial line and takes a 3-sample majority vote at mid-bit.
- Supports 5-9 data bits, optional odd/even parity and 1 or 2 stop bits.
- Delivers each word on a valid/ready handshake, with per-word parity/framing error flags and a sticky overrun flag.
- Sits between the pad-side serial input and the host-side receive FIFO/consumer.

Parameters:
CLK_FREQ, 50_000_000, input clock frequency in Hz
BAUD_RATE, 19200, line rate in bit/s
OVERSAMPLE, 16, sample ticks per bit; even, >= 8
DATA_BITS, 8, data bits per frame; 5..9
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, 1 or 2

Ports:
i_clk  in  1  system clock
i_rst  in  1  synchronous reset, active-high
i_rx_serial  in  1  asynchronous serial line, idle high
o_rx_data  out  DATA_BITS  received word, LSB = first data bit on the line
o_rx_valid  out  1  word available; held until accepted
i_rx_ready  in  1  consumer accepts; transfer occurs when o_rx_valid && i_rx_ready on a rising i_clk edge
o_parity_err  out  1  parity mismatch for the word currently presented
o_frame_err  out  1  a stop bit was sampled 0 for the word currently presented
o_overrun  out  1  sticky: at least one word was dropped since the last transfer
o_busy  out  1  a frame is being received

Behaviour:
- One clock, i_clk. i_rst is synchronous and active-high.
- While i_rst is high, at every edge:
  - state goes to IDLE and all counters to 0;
  - the synchroniser flops go to 1;
  - o_rx_data, o_rx_valid, o_parity_err, o_frame_err, o_overrun and o_busy go to 0.
- Reset mid-frame abandons the frame; no partial word is ever presented.
- i_rx_serial passes through a 2-flop synchroniser; all logic below uses the synchronised value (rx_s).
- Tick generator:
  - DIV = CLK_FREQ / (BAUD_RATE*OVERSAMPLE), integer truncation; elaboration fails if DIV < 1.
  - Produces a 1-cycle tick every DIV clocks.
  - Restarts at 0 on IDLE -> START so that tick phase aligns to the detected edge.
- Majority sample: a 3-tick window centred on tick OVERSAMPLE/2 of each bit (ticks OS/2-1, OS/2, OS/2+1); bit value = 2-of-3.
- States:
  - IDLE: arms only after rx_s == 1 has been seen. A 1->0 transition on rx_s goes to START; o_busy goes 1 on that same edge.
  - START: bit value 1 is a false start -> IDLE, no output, no flags. Value 0 -> DATA at the end of the bit (tick OVERSAMPLE-1).
  - DATA: DATA_BITS bits shifted in LSB first. Then PARITY if PARITY != 0, else STOP.
  - PARITY: expected bit = XOR of the data bits, inverted for odd. A mismatch latches perr.
  - STOP: STOP_BITS bits; any stop bit sampled 0 latches ferr. After the majority decision of the final stop bit, go to IDLE without waiting for the bit end, so back-to-back frames are received. o_busy drops to 0 on this edge.
- Delivery: on the edge after the final stop decision (latency = 1 clock):
  - If o_rx_valid == 0, or a transfer occurs on that same edge: load o_rx_data, o_parity_err and o_frame_err from the frame, and set o_rx_valid = 1.
  - Otherwise: drop the new word, keep the held word and its flags unchanged, and set o_overrun = 1.
- Transfer with no new word on the same edge: o_rx_valid, o_parity_err and o_frame_err go to 0. o_overrun also clears on any transfer.
- o_rx_data is stable while o_rx_valid is high.

Optional Feature:
UART_RX_BREAK_DETECT_EN
- Defined:
  - Adds output port o_break (1 bit, reset 0).
  - A frame whose start, data, parity and all stop samples are 0 is a break: no word is delivered, and o_break pulses high for 1 clock.
  - The FSM then enters BREAK and stays until rx_s == 1, then goes to IDLE.
- Undefined:
  - No o_break port and no BREAK state.
  - A break frame is delivered as data 0 with o_frame_err = 1 (and o_parity_err set if odd parity).
  - IDLE re-arms only after rx_s returns to 1.

Test Plan:
All scenarios use CLK_FREQ=1_600_000, BAUD_RATE=100_000, OVERSAMPLE=16 (DIV=1, bit = 16 clocks) and i_rx_ready=1 unless noted.
1. 8N1, send 0xAA -> o_rx_valid 1 clock after the stop mid-sample; o_rx_data=0xAA; o_parity_err=0, o_frame_err=0, o_overrun=0; o_busy low again.
2. PARITY=2, DATA_BITS=8: send 0x5A with parity bit 1 -> o_rx_data=0x5A, o_parity_err=1. Then send 0x5B with parity bit 1 -> o_parity_err=0.
3. 8N1, send 0x3C with stop bit driven 0 -> o_rx_data=0x3C, o_frame_err=1. A following clean 0x3C -> o_frame_err=0.
4. i_rx_ready=0, send 0x11 then 0x22 back-to-back -> o_rx_data stays 0x11 and o_overrun=1. Raise i_rx_ready for 1 clock -> o_rx_valid=0, o_overrun=0.
5. Low glitch of 4 clocks on i_rx_serial -> o_busy pulses, no o_rx_valid. Then DATA_BITS=5, STOP_BITS=2 (separate elaboration), send 0x15 -> o_rx_data=5'h15.
6. Assert i_rst for 1 clock during data bit 3 of 0xFF -> all outputs 0, nothing delivered. Then send 0x81 -> o_rx_data=0x81. With UART_RX_BREAK_DETECT_EN, hold the line low 20 bits -> single o_break pulse, no o_rx_valid.
